// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with sub-word loads, read-modify-write stores and misalignment errors.
// Define DMEM_DBG_PORT_EN to add the word-only debug port with round-robin arbitration.
module dmem_ctrl #(
  parameter int SYS_ADDR_SPACE   = 32,
  parameter int CACHE_DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        core_req_i,
  input  logic                        core_we_i,
  input  logic [2:0]                  core_funct3_i,
  input  logic [SYS_ADDR_SPACE-1:0]   core_addr_i,
  input  logic [CACHE_DATA_WIDTH-1:0] core_wdata_i,
  output logic                        core_gnt_o,
  output logic                        core_rvalid_o,
  output logic                        core_err_o,
`ifdef DMEM_DBG_PORT_EN
  input  logic                        dbg_req_i,
  input  logic                        dbg_we_i,
  input  logic [SYS_ADDR_SPACE-1:0]   dbg_addr_i,
  input  logic [CACHE_DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                        dbg_gnt_o,
  output logic                        dbg_rvalid_o,
`endif
  output logic [CACHE_DATA_WIDTH-1:0] rdata_o,
  output logic                        mem_re_o,
  output logic                        mem_we_o,
  output logic [SYS_ADDR_SPACE-1:0]   mem_addr_o,
  output logic [CACHE_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [CACHE_DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int AW = SYS_ADDR_SPACE;
  localparam int DW = CACHE_DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;
  state_t          state_q, state_d;
  logic            d_req, d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            dbg_q, we_q, err_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, rd_q;
  logic            gnt, sel_dbg, we_in, err_in, resp;
  logic [2:0]      f_in;
  logic [AW-1:0]   a_in;
  logic [DW-1:0]   wd_in, wr_word, ld_word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
`ifdef DMEM_DBG_PORT_EN
  assign d_req        = dbg_req_i;
  assign d_we         = dbg_we_i;
  assign d_addr       = dbg_addr_i;
  assign d_wdata      = dbg_wdata_i;
  assign dbg_gnt_o    = gnt & sel_dbg;
  assign dbg_rvalid_o = resp & dbg_q;
`else
  assign d_req   = 1'b0;
  assign d_we    = 1'b0;
  assign d_addr  = '0;
  assign d_wdata = '0;
`endif
  // dbg_q doubles as round-robin pointer and owner of the in-flight access
  assign sel_dbg = d_req & (~core_req_i | ~dbg_q);
  assign gnt     = rst_n_i & (state_q == IDLE) & (core_req_i | d_req);
  assign resp    = (state_q == RESP);
  always_comb begin
    f_in   = sel_dbg ? 3'b010 : core_funct3_i;
    a_in   = sel_dbg ? (d_addr & ~AW'(3)) : core_addr_i;
    we_in  = sel_dbg ? d_we : core_we_i;
    wd_in  = sel_dbg ? d_wdata : core_wdata_i;
    err_in = ~sel_dbg & ((we_in ? (f_in[2] | &f_in[1:0]) : (&f_in[1:0] | &f_in[2:1]))
           | (f_in[1:0] == 2'b01 & a_in[0]) | (f_in[1:0] == 2'b10 & |a_in[1:0]));
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = err_in ? RESP : !we_in ? RD : (f_in[1:0] == 2'b10) ? WR : RMW_RD;
      RD:      state_d = RESP;
      RMW_RD:  state_d = WR;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      dbg_q   <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        dbg_q   <= sel_dbg;
        we_q    <= we_in;
        err_q   <= err_in;
        f3_q    <= f_in;
        addr_q  <= a_in;
        wdata_q <= wd_in;
      end
      if (mem_re_o) rd_q <= mem_rdata_i;
    end
  end
  always_comb begin
    wr_word = rd_q;
    if (f3_q[1:0] == 2'b00) wr_word[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    else if (f3_q[1:0] == 2'b01) wr_word[16*addr_q[1] +: 16] = wdata_q[15:0];
    else wr_word = wdata_q;
  end
  always_comb begin
    byte_v  = rd_q[8*addr_q[1:0] +: 8];
    half_v  = rd_q[16*addr_q[1] +: 16];
    ld_word = (f3_q == 3'b000) ? {{(DW-8){byte_v[7]}}, byte_v}
            : (f3_q == 3'b100) ? {{(DW-8){1'b0}}, byte_v}
            : (f3_q == 3'b001) ? {{(DW-16){half_v[15]}}, half_v}
            : (f3_q == 3'b101) ? {{(DW-16){1'b0}}, half_v}
            : rd_q;
  end
  assign core_gnt_o    = gnt & ~sel_dbg;
  assign core_rvalid_o = resp & ~dbg_q;
  assign core_err_o    = resp & ~dbg_q & err_q;
  assign rdata_o       = (resp & ~we_q & ~err_q) ? ld_word : '0;
  assign mem_re_o      = (state_q == RD) | (state_q == RMW_RD);
  assign mem_we_o      = (state_q == WR);
  assign mem_addr_o    = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata_o   = mem_we_o ? wr_word : '0;
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; ports as listed (name  direction  width  meaning).
REQ-002 clk_i  in  1  clock, all state on rising edge.
REQ-003 rst_n_i  in  1  asynchronous active-low reset.
REQ-004 core_req_i  in  1  core request; held with all core_* fields stable until core_gnt_o.
REQ-005 core_we_i  in  1  1=store, 0=load.
REQ-006 core_funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use only 000/001/010.
REQ-007 core_addr_i  in  SYS_ADDR_SPACE  byte address.
REQ-008 core_wdata_i  in  CACHE_DATA_WIDTH  store data, right-aligned.
REQ-009 core_gnt_o  out  1  request accepted this cycle.
REQ-010 core_rvalid_o  out  1  one-cycle completion pulse for every accepted core request.
REQ-011 core_err_o  out  1  valid with core_rvalid_o; misaligned or illegal access.
REQ-012 dbg_req_i  in  1  debug request, word-only; same hold rule as core.
REQ-013 dbg_we_i  in  1  1=store, 0=load.
REQ-014 dbg_addr_i  in  SYS_ADDR_SPACE  byte address; bits [1:0] ignored.
REQ-015 dbg_wdata_i  in  CACHE_DATA_WIDTH  store word.
REQ-016 dbg_gnt_o  out  1  request accepted this cycle.
REQ-017 dbg_rvalid_o  out  1  one-cycle completion pulse.
REQ-018 rdata_o  out  CACHE_DATA_WIDTH  load result, shared; valid with either rvalid.
REQ-019 mem_re_o / mem_we_o  out  1 each  data-memory read/write enable.
REQ-020 mem_addr_o  out  SYS_ADDR_SPACE  word-aligned address ([1:0]=00), drives memory read and write addresses.
REQ-021 mem_wdata_o  out  CACHE_DATA_WIDTH  write word.
REQ-022 mem_rdata_i  in  CACHE_DATA_WIDTH  combinational read word; byte lane k = bits [8k+7:8k] for addr[1:0]=k.

Function
REQ-023 FSM states IDLE, RD, RMW_RD, WR, RESP; grants issued only in IDLE, combinationally from req and arbitration; request captured at the granting edge.
REQ-024 Arbitration: single requester wins; both requesting -> round-robin, grant the port not granted last; after reset core wins first.
REQ-025 Transitions from IDLE: load -> RD; word store -> WR; byte/half store -> RMW_RD; error -> RESP; RD->RESP, RMW_RD->WR, WR->RESP, RESP->IDLE.
REQ-026 RD/RMW_RD: mem_re_o=1, mem_rdata_i registered at end of state; WR: mem_we_o=1 for exactly one cycle; mem_re_o and mem_we_o never both 1.
REQ-027 RMW: WR writes the read word with only addressed lane(s) replaced by core_wdata_i[7:0] or [15:0]; other bytes unchanged.
REQ-028 Latency from grant cycle T: load and word store rvalid at T+2; sub-word store at T+3; error at T+1; throughput one access per 3 cycles minimum.
REQ-029 Load extraction by addr[1:0]: B/H sign-extended, BU/HU zero-extended, W unchanged; rdata_o=0 for stores and errors.
REQ-030 Error: H/HU with addr[0]=1, W with addr[1:0]!=00, or funct3 not listed (load: 011/110/111; store: any except 000/001/010) -> no memory access, core_err_o=1 with rvalid; dbg never errors.
REQ-031 rvalid is routed only to the granted port; requests arriving outside IDLE wait (no gnt).

Reset
REQ-032 Reset SHALL force IDLE, all outputs 0, round-robin pointer to "dbg last"; gnt, rvalid, mem_re_o, mem_we_o drop asynchronously.
REQ-033 Reset mid-operation SHALL abandon the in-flight request with no rvalid and no further memory write.

Configuration
REQ-034 DMEM_DBG_PORT_EN defined: dbg_* ports and round-robin arbitration present.
REQ-035 DMEM_DBG_PORT_EN undefined: dbg_* ports absent, core always granted in IDLE, all other behaviour identical.

Verification
REQ-036 Word at 0x100 = 0x8899AABB; core LB 0x101 -> rvalid at T+2, rdata_o=0xFFFFFFAA; LBU 0x101 -> 0x000000AA.
REQ-037 Core SB 0x102 data 0x55 -> mem_re_o at T+1, mem_we_o at T+2 with 0x8855AABB, rvalid T+3, err 0.
REQ-038 Core LW 0x102 -> rvalid at T+1, core_err_o=1, rdata_o=0, no mem_re_o/mem_we_o.
REQ-039 Core and dbg request continuously from reset -> grants core, dbg, core, dbg; each rvalid only on its own port.
REQ-040 Assert rst_n_i during WR of a word store -> mem_we_o drops immediately, no rvalid, FSM IDLE after release.
